vga_axis_timing: RTL and testbench

//  Parametrised single-axis VGA timing generator; successor to the fixed 0..524 vertical counter.
//  - One instance per axis: horizontal (enable tied high) or vertical (enable = horizontal terminal).
//  - Produces the position count, region state, sync pulse (programmable polarity), active-video flag
//    and a terminal strobe for cascading.
//  - Sits between the 25 MHz pixel clock domain and the pixel/colour generator.

---
 rtl/vga_timing_pkg.sv | 24 ++
 rtl/vga_axis_if.sv | 25 ++
 rtl/vga_axis_timing.sv | 86 ++++++++
 tb/tb_vga_axis_timing.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and the per-axis region encoding.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FRONT  = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BACK   = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FRONT  = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BACK   = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Region encoding doubles as the FSM state; order matches the scan order of one axis.
  typedef enum logic [1:0] {
    REG_ACTIVE = 2'd0,
    REG_FRONT  = 2'd1,
    REG_SYNC   = 2'd2,
    REG_BACK   = 2'd3
  } region_t;

endpackage

// File: rtl/vga_axis_if.sv
// Per-axis timing bundle: advance/resync controls in, position and decoded timing out.
interface vga_axis_if #(
  parameter int unsigned CNT_W = 16
);

  logic             enable_count;
  logic             restart;
  logic [CNT_W-1:0] count;
  logic [1:0]       region;
  logic             sync_out;
  logic             active_video;
  logic             first;
  logic             terminal_tc;

  modport master (
    input  enable_count, restart,
    output count, region, sync_out, active_video, first, terminal_tc
  );

  modport slave (
    output enable_count, restart,
    input  count, region, sync_out, active_video, first, terminal_tc
  );

endinterface

// File: rtl/vga_axis_timing.sv
// Single-axis VGA timing generator; cascade a vertical instance on the horizontal terminal_tc.
module vga_axis_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned ACTIVE   = V_ACTIVE,
  parameter int unsigned FRONT    = V_FRONT,
  parameter int unsigned SYNC     = V_SYNC,
  parameter int unsigned BACK     = V_BACK,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic      clk_25MHz,
  input  logic      reset,
  vga_axis_if.master axis
);

  localparam int unsigned TOTAL = ACTIVE + FRONT + SYNC + BACK;

  localparam logic [CNT_W-1:0] ACTIVE_END = CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] FRONT_END  = CNT_W'(ACTIVE + FRONT - 1);
  localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FRONT + SYNC - 1);
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);

  localparam logic SYNC_ON  = SYNC_POL;
  localparam logic SYNC_OFF = ~SYNC_POL;

  if (longint'(TOTAL) > (longint'(1) << CNT_W)) begin : g_width_check
    $error("vga_axis_timing: TOTAL does not fit in CNT_W bits");
  end

  if (ACTIVE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_segment_check
    $error("vga_axis_timing: every segment length must be at least 1");
  end

  region_t          region_q, region_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sync_q, sync_d;
  logic             active_q, active_d;
  logic             first_q, first_d;

  // Outputs are decoded from the next state so they land on the same edge as count.
  always_comb begin
    count_d  = count_q;
    region_d = region_q;
    if (axis.restart) begin
      count_d  = '0;
      region_d = REG_ACTIVE;
    end else if (axis.enable_count) begin
      count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
      unique case (region_q)
        REG_ACTIVE: if (count_q == ACTIVE_END) region_d = REG_FRONT;
        REG_FRONT:  if (count_q == FRONT_END)  region_d = REG_SYNC;
        REG_SYNC:   if (count_q == SYNC_END)   region_d = REG_BACK;
        REG_BACK:   if (count_q == LAST)       region_d = REG_ACTIVE;
      endcase
    end
    sync_d   = (region_d == REG_SYNC) ? SYNC_ON : SYNC_OFF;
    active_d = (region_d == REG_ACTIVE);
    first_d  = (count_d == '0);
  end

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      count_q  <= '0;
      region_q <= REG_ACTIVE;
      sync_q   <= SYNC_OFF;
      active_q <= 1'b1;
      first_q  <= 1'b1;
    end else begin
      count_q  <= count_d;
      region_q <= region_d;
      sync_q   <= sync_d;
      active_q <= active_d;
      first_q  <= first_d;
    end
  end

  // Combinational so a cascaded axis advances on the very edge this one wraps.
  assign axis.terminal_tc  = axis.enable_count & (count_q == LAST) & ~axis.restart & ~reset;
  assign axis.count        = count_q;
  assign axis.region       = region_q;
  assign axis.sync_out     = sync_q;
  assign axis.active_video = active_q;
  assign axis.first        = first_q;

endmodule

// File: tb/tb_vga_axis_timing.sv
// Randomized bench for vga_axis_timing against a position-arithmetic reference model.
module tb_vga_axis_timing;
  import vga_timing_pkg::*;

  localparam int CW = 8;
  localparam int SA = 4;
  localparam int SF = 2;
  localparam int SS = 3;
  localparam int SB = 1;
  localparam int ST = SA + SF + SS + SB;
  localparam int LINE_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int FRAME_TOTAL = 525;

  logic clk_25MHz = 1'b0;
  always #20 clk_25MHz = ~clk_25MHz;

  logic reset     = 1'b1;
  logic lineReset = 1'b1;
  logic restart   = 1'b0;
  logic enable    = 1'b0;

  vga_axis_if #(.CNT_W(CW)) smallIf ();
  vga_axis_if #(.CNT_W(CW)) smallPolIf ();
  vga_axis_if #(.CNT_W(16)) lineIf ();
  vga_axis_if #(.CNT_W(16)) frameIf ();

  assign smallIf.enable_count    = enable;
  assign smallIf.restart         = restart;
  assign smallPolIf.enable_count = enable;
  assign smallPolIf.restart      = restart;
  assign lineIf.enable_count     = 1'b1;
  assign lineIf.restart          = 1'b0;
  assign frameIf.enable_count    = smallIf.terminal_tc;
  assign frameIf.restart         = 1'b0;

  vga_axis_timing #(.CNT_W(CW), .ACTIVE(SA), .FRONT(SF), .SYNC(SS), .BACK(SB), .SYNC_POL(1'b0))
    uSmall (.clk_25MHz(clk_25MHz), .reset(reset), .axis(smallIf));

  vga_axis_timing #(.CNT_W(CW), .ACTIVE(SA), .FRONT(SF), .SYNC(SS), .BACK(SB), .SYNC_POL(1'b1))
    uSmallPol (.clk_25MHz(clk_25MHz), .reset(reset), .axis(smallPolIf));

  vga_axis_timing #(.CNT_W(16), .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
                    .SYNC_POL(1'b0))
    uLine (.clk_25MHz(clk_25MHz), .reset(lineReset), .axis(lineIf));

  vga_axis_timing uFrame (.clk_25MHz(clk_25MHz), .reset(reset), .axis(frameIf));

  int checks = 0;
  int errors = 0;
  int sCnt = 0;
  int lCnt = 0;
  int fCnt = 0;
  int edgeIdx = 0;

  function automatic int regionOf(input int c, input int a, input int f, input int s);
    if (c < a) return 0;
    if (c < a + f) return 1;
    if (c < a + f + s) return 2;
    return 3;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic checkRegisters();
    int sr;
    sr = regionOf(sCnt, SA, SF, SS);
    checkOutput("small_count", 32'(smallIf.count), sCnt);
    checkOutput("small_region", 32'(smallIf.region), sr);
    checkOutput("small_sync", 32'(smallIf.sync_out), (sr == 2) ? 0 : 1);
    checkOutput("small_active", 32'(smallIf.active_video), (sCnt < SA) ? 1 : 0);
    checkOutput("small_first", 32'(smallIf.first), (sCnt == 0) ? 1 : 0);
    checkOutput("pol_sync", 32'(smallPolIf.sync_out), (sCnt >= 6 && sCnt <= 8) ? 1 : 0);
    checkOutput("line_count", 32'(lineIf.count), lCnt);
    checkOutput("line_sync", 32'(lineIf.sync_out), (lCnt >= 656 && lCnt <= 751) ? 0 : 1);
    checkOutput("line_active", 32'(lineIf.active_video), (lCnt < 640) ? 1 : 0);
    checkOutput("frame_count", 32'(frameIf.count), fCnt);
    checkOutput("frame_region", 32'(frameIf.region), regionOf(fCnt, 480, 10, 2));
    checkOutput("frame_sync", 32'(frameIf.sync_out), (fCnt >= 490 && fCnt <= 491) ? 0 : 1);
  endtask

  // One clock: drive at negedge, check combinational terminals before the edge, registers after.
  task automatic applyStimulus(input logic r, input logic rs, input logic en);
    logic expSmallTc, expLineTc, expFrameTc;
    @(negedge clk_25MHz);
    reset   = r;
    restart = rs;
    enable  = en;
    #1;
    expSmallTc = en && !rs && !r && (sCnt == ST - 1);
    expLineTc  = !lineReset && (lCnt == LINE_TOTAL - 1);
    expFrameTc = expSmallTc && (fCnt == FRAME_TOTAL - 1);
    checkOutput("small_tc", 32'(smallIf.terminal_tc), 32'(expSmallTc));
    checkOutput("pol_tc", 32'(smallPolIf.terminal_tc), 32'(expSmallTc));
    checkOutput("line_tc", 32'(lineIf.terminal_tc), 32'(expLineTc));
    checkOutput("frame_tc", 32'(frameIf.terminal_tc), 32'(expFrameTc));
    @(posedge clk_25MHz);
    sCnt = (r || rs) ? 0 : (en ? (sCnt + 1) % ST : sCnt);
    fCnt = r ? 0 : (expSmallTc ? (fCnt + 1) % FRAME_TOTAL : fCnt);
    lCnt = lineReset ? 0 : (lCnt + 1) % LINE_TOTAL;
    edgeIdx++;
    #1;
    checkRegisters();
  endtask

  initial begin
    int wrapAt;
    int prevF;
    int syncLowCycles;

    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("reset_count", 32'(smallIf.count), 0);
    checkOutput("reset_region", 32'(smallIf.region), 0);
    checkOutput("reset_sync", 32'(smallIf.sync_out), 1);
    checkOutput("reset_pol_sync", 32'(smallPolIf.sync_out), 0);
    checkOutput("reset_first", 32'(smallIf.first), 1);
    lineReset = 1'b0;

    repeat (10) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("wrap_to_zero", 32'(smallIf.count), 0);

    repeat (5) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("hold_count", 32'(smallIf.count), 6);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("resume_count", 32'(smallIf.count), 7);

    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("restart_in_sync", 32'(smallIf.sync_out), 1);

    repeat (9) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("at_last", 32'(smallIf.count), 9);
    applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("reset_mid", 32'(smallIf.count), 0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 19) == 0),
                    1'($urandom_range(0, 3) != 0));
    end

    applyStimulus(1'b1, 1'b0, 1'b1);
    edgeIdx = 0;
    wrapAt = -1;
    syncLowCycles = 0;
    for (int i = 0; i < 5300; i++) begin
      prevF = 32'(frameIf.count);
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (wrapAt < 0 && prevF == 524 && frameIf.count == 16'd0) wrapAt = edgeIdx;
      if (frameIf.sync_out == 1'b0) syncLowCycles++;
    end
    checkOutput("frame_wrap_edge", 32'(wrapAt), 32'(ST * FRAME_TOTAL));
    checkOutput("frame_sync_cycles", 32'(syncLowCycles), 32'(2 * ST));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
